// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch front end: word type, fetch FSM
// states and the architectural reset/bubble constants.
package fetch_stage_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {
      FETCH = 1'b0,
      HELD  = 1'b1
   } fetch_state_t;

   localparam word_t RESET_PC_DEF  = 32'h0000_0000;
   localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

   function automatic word_t word_align(input word_t addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Priority: reset, then hold, then bubble, then load.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instr,
   output logic        valid
);

   always_ff @(posedge clk) begin
      if (reset || (!hold && bubble)) begin
         pc       <= 32'h0000_0000;
         pc_plus4 <= 32'h0000_0000;
         instr    <= NOP_INSTR;
         valid    <= 1'b0;
      end else if (!hold) begin
         pc       <= load_pc;
         pc_plus4 <= load_pc + 32'd4;
         instr    <= load_instr;
         valid    <= 1'b1;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem request handshake, one-entry hold buffer for a
// word returned during a stall, and the IF/ID register feeding decode.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter word_t RESET_PC  = RESET_PC_DEF,
   parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] pc_ID,
   output logic [31:0] pc_plus4_ID,
   output logic [31:0] instr_ID,
   output logic        valid_ID
);

   // Handshake: imem_req/imem_addr depend only on state and stay stable
   // until a cycle with imem_ready=1 completes the transfer.

   fetch_state_t state, state_next;

   word_t pc, pc_next;
   logic  pend, pend_next;
   word_t pend_target, pend_target_next;
   word_t hold_word, hold_pc;
   logic  hold_we;

   logic  ifid_hold, ifid_bubble;
   word_t ifid_pc, ifid_instr;

   logic  redirect;
   word_t redirect_target;

   assign redirect        = !stall && (branch_taken || jr);
   assign redirect_target = word_align(jr ? jr_target : branch_target);
   assign imem_addr       = pc;

   always_ff @(posedge clk) begin
      if (reset) state <= FETCH;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH: if (imem_ready && stall && !pend) state_next = HELD;
         HELD:  if (!stall) state_next = FETCH;
         default: state_next = FETCH;
      endcase
   end

   always_comb begin
      imem_req         = 1'b0;
      ifid_hold        = 1'b0;
      ifid_bubble      = 1'b0;
      ifid_pc          = pc;
      ifid_instr       = imem_rdata;
      pc_next          = pc;
      pend_next        = pend;
      pend_target_next = pend_target;
      hold_we          = 1'b0;
      case (state)
         FETCH: begin
            imem_req = !reset;
            if (imem_ready) begin
               if (redirect) begin
                  pc_next     = redirect_target;
                  pend_next   = 1'b0;
                  ifid_bubble = 1'b1;
               end else if (pend) begin
                  // Word at the stale address is discarded.
                  pc_next     = pend_target;
                  pend_next   = 1'b0;
                  ifid_hold   = stall;
                  ifid_bubble = !stall;
               end else if (stall) begin
                  hold_we   = 1'b1;
                  pc_next   = pc + 32'd4;
                  ifid_hold = 1'b1;
               end else begin
                  pc_next     = pc + 32'd4;
                  ifid_bubble = flush;
               end
            end else if (redirect) begin
               pend_next        = 1'b1;
               pend_target_next = redirect_target;
               ifid_bubble      = 1'b1;
            end else begin
               ifid_hold   = stall;
               ifid_bubble = !stall;
            end
         end
         HELD: begin
            if (stall) begin
               ifid_hold = 1'b1;
            end else if (redirect) begin
               pc_next     = redirect_target;
               ifid_bubble = 1'b1;
            end else if (flush) begin
               // Refetch the squashed buffered instruction.
               pc_next     = hold_pc;
               ifid_bubble = 1'b1;
            end else begin
               ifid_pc    = hold_pc;
               ifid_instr = hold_word;
            end
         end
         default: ifid_hold = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc          <= RESET_PC;
         pend        <= 1'b0;
         pend_target <= 32'h0000_0000;
         hold_word   <= 32'h0000_0000;
         hold_pc     <= 32'h0000_0000;
      end else begin
         pc          <= pc_next;
         pend        <= pend_next;
         pend_target <= pend_target_next;
         if (hold_we) begin
            hold_word <= imem_rdata;
            hold_pc   <= pc;
         end
      end
   end

   if_id_reg #(
      .NOP_INSTR(NOP_INSTR)
   ) u_if_id_reg (
      .clk       (clk),
      .reset     (reset),
      .hold      (ifid_hold),
      .bubble    (ifid_bubble),
      .load_pc   (ifid_pc),
      .load_instr(ifid_instr),
      .pc        (pc_ID),
      .pc_plus4  (pc_plus4_ID),
      .instr     (instr_ID),
      .valid     (valid_ID)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns addr ^ C0DE_0000, so every
// expected instruction word is derived from its fetch address.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jr;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] pc_ID;
   logic [31:0] pc_plus4_ID;
   logic [31:0] instr_ID;
   logic        valid_ID;

   int check_count = 0;
   int error_count = 0;

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .flush        (flush),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jr           (jr),
      .jr_target    (jr_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .pc_ID        (pc_ID),
      .pc_plus4_ID  (pc_plus4_ID),
      .instr_ID     (instr_ID),
      .valid_ID     (valid_ID)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic [31:0] p, input logic v);
      check({tag, "_valid"}, {31'd0, valid_ID}, {31'd0, v});
      if (v) begin
         check({tag, "_pc"}, pc_ID, p);
         check({tag, "_pc4"}, pc_plus4_ID, p + 32'd4);
         check({tag, "_instr"}, instr_ID, word_at(p));
      end else begin
         check({tag, "_nop"}, instr_ID, 32'h0000_0000);
      end
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      branch_taken = 1'b0; branch_target = '0; jr = 1'b0; jr_target = '0;
      imem_ready = 1'b1;

      // reset state
      tick();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("rst_pc_id", pc_ID, 32'h0);
      check("rst_pc4_id", pc_plus4_ID, 32'h0);
      check_id("rst", 32'h0, 1'b0);
      reset = 1'b0;
      #1;
      check("rel_req", {31'd0, imem_req}, 32'd1);
      check("rel_addr", imem_addr, 32'h0);

      // streaming with single-cycle memory
      tick(); check_id("s0", 32'h0, 1'b1); check("s0_addr", imem_addr, 32'h4);
      tick(); check_id("s1", 32'h4, 1'b1); check("s1_addr", imem_addr, 32'h8);

      // stall two cycles at pc=8: word at 8 parks in the hold buffer
      stall = 1'b1;
      tick(); check_id("st0", 32'h4, 1'b1); check("st0_req", {31'd0, imem_req}, 32'd0);
      tick(); check_id("st1", 32'h4, 1'b1); check("st1_req", {31'd0, imem_req}, 32'd0);
      stall = 1'b0;
      tick(); check_id("st2", 32'h8, 1'b1); check("st2_addr", imem_addr, 32'hC);

      // taken branch at pc=C
      branch_taken = 1'b1; branch_target = 32'h40;
      tick(); check_id("br0", 32'h0, 1'b0); check("br0_addr", imem_addr, 32'h40);
      branch_taken = 1'b0;
      tick(); check_id("br1", 32'h40, 1'b1); check("br1_addr", imem_addr, 32'h44);

      // move to 0x10, then memory stalls three cycles with jr in the first
      branch_taken = 1'b1; branch_target = 32'h10;
      tick(); check("b10_addr", imem_addr, 32'h10);
      branch_taken = 1'b0;
      imem_ready = 1'b0; jr = 1'b1; jr_target = 32'h203;
      tick(); check_id("w0", 32'h0, 1'b0); check("w0_addr", imem_addr, 32'h10);
      jr = 1'b0;
      tick(); check_id("w1", 32'h0, 1'b0); check("w1_addr", imem_addr, 32'h10);
      tick(); check_id("w2", 32'h0, 1'b0); check("w2_req", {31'd0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      tick(); check_id("w3", 32'h0, 1'b0); check("w3_addr", imem_addr, 32'h200);
      tick(); check_id("w4", 32'h200, 1'b1); check("w4_addr", imem_addr, 32'h204);

      // branch together with stall is ignored, then redirects from HELD
      branch_taken = 1'b1; branch_target = 32'h80; stall = 1'b1;
      tick(); check_id("bs0", 32'h200, 1'b1); check("bs0_req", {31'd0, imem_req}, 32'd0);
      stall = 1'b0;
      tick(); check_id("bs1", 32'h0, 1'b0); check("bs1_addr", imem_addr, 32'h80);
      branch_taken = 1'b0;
      tick(); check_id("bs2", 32'h80, 1'b1);

      // flush while HELD drops the buffered word and refetches it
      stall = 1'b1;
      tick(); check_id("fh0", 32'h80, 1'b1);
      stall = 1'b0; flush = 1'b1;
      tick(); check_id("fh1", 32'h0, 1'b0); check("fh1_addr", imem_addr, 32'h84);
      flush = 1'b0;
      tick(); check_id("fh2", 32'h84, 1'b1); check("fh2_addr", imem_addr, 32'h88);

      // pending redirect overwritten; jr beats branch
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
      tick(); check("pw0_addr", imem_addr, 32'h88);
      jr = 1'b1; jr_target = 32'h300;
      tick(); check("pw1_addr", imem_addr, 32'h88);
      jr = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;
      tick(); check_id("pw2", 32'h0, 1'b0); check("pw2_addr", imem_addr, 32'h300);

      // misaligned target is forced to word alignment; pc wraps at 2^32
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      tick(); check("wr0_addr", imem_addr, 32'hFFFF_FFFC);
      branch_taken = 1'b0;
      tick();
      check("wr1_pc", pc_ID, 32'hFFFF_FFFC);
      check("wr1_pc4", pc_plus4_ID, 32'h0000_0000);
      check("wr1_addr", imem_addr, 32'h0000_0000);

      // flush with a completed fetch squashes it into a bubble
      flush = 1'b1;
      tick(); check_id("ff0", 32'h0, 1'b0);
      flush = 1'b0;

      // reset with a pending redirect outstanding
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h500;
      tick();
      branch_taken = 1'b0; reset = 1'b1;
      tick();
      check("mr_req", {31'd0, imem_req}, 32'd0);
      check_id("mr", 32'h0, 1'b0);
      reset = 1'b0; imem_ready = 1'b1;
      #1;
      check("mr_addr", imem_addr, 32'h0);
      tick(); check_id("mr1", 32'h0, 1'b1); check("mr1_addr", imem_addr, 32'h4);

      $display("CHECKS %0d ERRORS %0d", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch front end feeding the decode stage.
- Owns the program counter, the instruction-memory request handshake, a one-entry hold buffer and the IF/ID pipeline register.
- Consumes stall and flush from the hazard unit, and branch/jr redirects resolved in ID.
- Produces the pc/instruction/valid triple read by decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on a bubble or flush

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  hazard unit: squash the IF/ID contents
branch_taken  input  1  branch resolved taken in ID
branch_target  input  32  branch destination
jr  input  1  jump-register in ID
jr_target  input  32  jr destination (rs value)
imem_req  output  1  instruction-memory request
imem_addr  output  32  word-aligned fetch address
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory completes the request this cycle
pc_ID  output  32  PC of the instruction in IF/ID
pc_plus4_ID  output  32  pc_ID+4
instr_ID  output  32  instruction in IF/ID
valid_ID  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (sync, high):
  - pc=RESET_PC, state=FETCH, pend=0.
  - pc_ID=0, pc_plus4_ID=0, instr_ID=NOP_INSTR, valid_ID=0.
  - imem_req=0 while reset=1.
- redirect = !stall & (branch_taken | jr). jr wins if both are high. Target = selected target with bits [1:0] forced to 00.
- stall has priority: while stall=1, redirect and flush are ignored and IF/ID holds.
- flush without redirect: IF/ID takes a bubble; the PC path is unaffected.
- Handshake:
  - imem_req and imem_addr are combinational from state.
  - Once imem_req=1, it and imem_addr stay stable until a cycle with imem_ready=1.
  - Single-cycle memory (ready tied high) gives 1 instruction per cycle.
  - Fetch-to-IF/ID latency is 1 edge after the ready cycle.
- PC increment: pc+4, modulo 2^32; FFFF_FFFC wraps to 0000_0000.
- Bubble: valid_ID=0, instr_ID=NOP_INSTR; pc_ID and pc_plus4_ID are don't-care (drive 0).
- State FETCH (imem_req=1, imem_addr=pc):
  - ready & redirect: discard rdata; pc<=target; IF/ID bubble.
  - !ready & redirect: pend<=1, pend_target<=target; IF/ID bubble; the request stays on the old address.
  - ready & pend (no new redirect): discard rdata; pc<=pend_target; pend<=0; IF/ID bubble. If a new redirect arrives in the same cycle, the new target wins.
  - Redirect while pend=1 and !ready: overwrite pend_target (newest wins).
  - ready & !stall & !pend: IF/ID<={pc, pc+4, rdata, 1}; pc<=pc+4.
  - ready & stall & !pend: buf<=rdata, buf_pc<=pc; pc<=pc+4; go to HELD; IF/ID holds.
  - ready & stall & pend: discard; pc<=pend_target; pend<=0; IF/ID holds.
  - !ready & !stall: IF/ID bubble.
  - !ready & stall: IF/ID holds.
- State HELD (imem_req=0):
  - stall: stay; IF/ID holds.
  - !stall & redirect: drop buf; pc<=target; IF/ID bubble; go to FETCH.
  - !stall & flush without redirect: drop buf, IF/ID bubble, go to FETCH, and pc<=buf_pc so the dropped instruction is refetched.
  - !stall otherwise: IF/ID<={buf_pc, buf_pc+4, buf, 1}; go to FETCH.
- Reset mid-request: abandon the request; after reset, fetch restarts at RESET_PC.

Decomposition:
- Shared cpu package: fetch state enum (FETCH, HELD), NOP_INSTR and RESET_PC constants, 32-bit word typedef.
- One natural sub-module: if_id_reg, holding the pipeline register with hold/bubble/load controls. The fetch FSM, PC and hold buffer stay in fetch_stage.

Test Plan:
- Reset, ready=1, rdata=pc-derived for 4 cycles -> imem_addr 0,4,8,C; pc_ID 0,4,8 with valid_ID=1; instr_ID matches.
- stall=1 for 2 cycles at pc=8 with ready=1 -> IF/ID holds pc_ID=4; HELD captures the word at 8; after stall drops, pc_ID=8 then C, with no duplicate or lost instruction.
- branch_taken=1, branch_target=0x40 while pc=0xC -> next cycle valid_ID=0, imem_addr=0x40; the word at 0xC never appears in IF/ID.
- ready held 0 for 3 cycles at addr 0x10, jr=1 with jr_target=0x203 in cycle 1 -> imem_addr stays 0x10 until ready; then next addr 0x200; 3+1 bubbles.
- branch_taken=1 and stall=1 together -> redirect ignored, pc and IF/ID unchanged; branch_taken alone next cycle redirects.
- pc=FFFF_FFFC, ready=1 -> next imem_addr=0000_0000, pc_plus4_ID=0000_0000.
